// File: rtl/mips_register_file_if.sv
// Register-file bus: read indices/data and the write-back port of the
// single-cycle MIPS datapath, grouped so the datapath and bench share one bundle.
`timescale 1ns/1ps
interface mips_register_file_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic                  reg_write;
  logic [ADDR_WIDTH-1:0] read_reg1;
  logic [ADDR_WIDTH-1:0] read_reg2;
  logic [ADDR_WIDTH-1:0] write_reg;
  logic [DATA_WIDTH-1:0] write_data;
  logic [DATA_WIDTH-1:0] read_data1;
  logic [DATA_WIDTH-1:0] read_data2;

  modport master (
    output reg_write, read_reg1, read_reg2, write_reg, write_data,
    input  read_data1, read_data2
  );

  modport slave (
    input  reg_write, read_reg1, read_reg2, write_reg, write_data,
    output read_data1, read_data2
  );
endinterface

// File: rtl/mips_register_file.sv
// 32 x 32-bit MIPS register file: two combinational read ports built from
// 8:1/4:1 muxes, one synchronous write port, $0 hardwired to zero.
`timescale 1ns/1ps
module mips_mux4_32 #(
  parameter int W = 32
) (
  input  logic [1:0]   sel,
  input  logic [W-1:0] d0,
  input  logic [W-1:0] d1,
  input  logic [W-1:0] d2,
  input  logic [W-1:0] d3,
  output logic [W-1:0] y
);
  always_comb begin
    case (sel)
      2'd0:    y = d0;
      2'd1:    y = d1;
      2'd2:    y = d2;
      default: y = d3;
    endcase
  end
endmodule

module mips_mux8_32 #(
  parameter int W = 32
) (
  input  logic [2:0]   sel,
  input  logic [W-1:0] d0,
  input  logic [W-1:0] d1,
  input  logic [W-1:0] d2,
  input  logic [W-1:0] d3,
  input  logic [W-1:0] d4,
  input  logic [W-1:0] d5,
  input  logic [W-1:0] d6,
  input  logic [W-1:0] d7,
  output logic [W-1:0] y
);
  always_comb begin
    case (sel)
      3'd0:    y = d0;
      3'd1:    y = d1;
      3'd2:    y = d2;
      3'd3:    y = d3;
      3'd4:    y = d4;
      3'd5:    y = d5;
      3'd6:    y = d6;
      default: y = d7;
    endcase
  end
endmodule

module mips_read_port_32 (
  input  logic [4:0]  sel,
  input  logic [31:0] regs [32],
  output logic [31:0] y
);
  logic [31:0] bank_y [4];

  // Low index bits pick within a bank of eight, high bits pick the bank.
  for (genvar g = 0; g < 4; g++) begin : g_bank
    mips_mux8_32 #(.W(32)) u_bank (
      .sel (sel[2:0]),
      .d0  (regs[g*8+0]),
      .d1  (regs[g*8+1]),
      .d2  (regs[g*8+2]),
      .d3  (regs[g*8+3]),
      .d4  (regs[g*8+4]),
      .d5  (regs[g*8+5]),
      .d6  (regs[g*8+6]),
      .d7  (regs[g*8+7]),
      .y   (bank_y[g])
    );
  end

  mips_mux4_32 #(.W(32)) u_final (
    .sel (sel[4:3]),
    .d0  (bank_y[0]),
    .d1  (bank_y[1]),
    .d2  (bank_y[2]),
    .d3  (bank_y[3]),
    .y   (y)
  );
endmodule

module mips_register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_REGS   = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mips_register_file_if.slave  rf
);
  logic [DATA_WIDTH-1:0] regs_q   [1:NUM_REGS-1];
  logic [DATA_WIDTH-1:0] regs_d   [1:NUM_REGS-1];
  logic                  write_en [1:NUM_REGS-1];
  logic [DATA_WIDTH-1:0] reg_view [NUM_REGS];

  // One-hot decode gated by reg_write; index 0 has no storage, so no enable.
  always_comb begin
    for (int i = 1; i < NUM_REGS; i++) begin
      write_en[i] = rf.reg_write && (rf.write_reg == ADDR_WIDTH'(i));
      regs_d[i]   = write_en[i] ? rf.write_data : regs_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      for (int i = 1; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
    end
  end

  assign reg_view[0] = '0;
  for (genvar r = 1; r < NUM_REGS; r++) begin : g_view
    assign reg_view[r] = regs_q[r];
  end

  // No write bypass: a same-index read sees the old value until the edge.
  mips_read_port_32 u_rd1 (
    .sel  (rf.read_reg1),
    .regs (reg_view),
    .y    (rf.read_data1)
  );

  mips_read_port_32 u_rd2 (
    .sel  (rf.read_reg2),
    .regs (reg_view),
    .y    (rf.read_data2)
  );
endmodule
